// File: rtl/risc_v_cpu_core.sv
// Single-cycle RV32I core: fetch, execute and write-back of one instruction per rising clock edge.
// Combinational fetch/decode/load path, no stalls; state is held in the PC, register file and data memory.

module rv_imem #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_instr
);
  localparam int IW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

  logic [7:0]  memory [IMEM_BYTES];
  logic [31:0] w_byte_addr [4];
  logic [7:0]  w_byte [4];

  // Bytes past the end of the array read as zero, so a fetch may straddle the boundary.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_byte_addr[k] = i_addr + 32'(k);
      w_byte[k]      = (w_byte_addr[k] < 32'(IMEM_BYTES)) ? memory[w_byte_addr[k][IW-1:0]] : 8'h00;
    end
  end

  assign o_instr = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
endmodule

module rv_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_pc
);
  logic [31:0] pc_addr;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) pc_addr <= RESET_PC;
    else            pc_addr <= i_next_pc;
  end

  assign o_pc = pc_addr;
endmodule

module rv_regfile (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_dat,
  output logic [31:0] o_rs2_dat,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_dat
);
  logic [31:0] registers [32];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && (i_rd_addr != 5'd0)) begin
      registers[i_rd_addr] <= i_rd_dat;
    end
  end

  assign o_rs1_dat = (i_rs1_addr == 5'd0) ? '0 : registers[i_rs1_addr];
  assign o_rs2_dat = (i_rs2_addr == 5'd0) ? '0 : registers[i_rs2_addr];
endmodule

module rv_dmem #(
  parameter int DMEM_WORDS = 64,
  parameter int AW         = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] memory [DMEM_WORDS];

  // Contents survive reset; reset only blocks the store of the aborted instruction.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
    end else if (i_we) begin
      for (int b = 0; b < 4; b++)
        if (i_be[b]) memory[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = memory[i_idx];
endmodule

module risc_v_cpu_core #(
  parameter int          IMEM_BYTES = 1024,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] out
);
  localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0]   w_pc, w_instr, w_next_pc, w_rs1_val, w_rs2_val, w_wb;
  logic [31:0]   w_mem_addr, w_ld_word, w_st_data;
  logic [31:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [15:0]   w_ld_half;
  logic [7:0]    w_ld_byte;
  logic [6:0]    w_opcode, w_f7;
  logic [4:0]    w_rd;
  logic [2:0]    w_f3;
  logic [3:0]    w_st_be;
  logic          w_rd_we, w_rf_we, w_st_we;
  logic [AW-1:0] w_didx;

  function automatic logic [31:0] f_alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic f_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  rv_imem #(.IMEM_BYTES(IMEM_BYTES)) uut_instruction (
    .i_addr (w_pc),
    .o_instr(w_instr)
  );

  rv_pc #(.RESET_PC(RESET_PC)) program_counter (
    .i_clock  (clock),
    .i_reset_n(reset),
    .i_next_pc(w_next_pc),
    .o_pc     (w_pc)
  );

  rv_regfile registers_bank (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_rs1_addr(w_instr[19:15]),
    .i_rs2_addr(w_instr[24:20]),
    .o_rs1_dat (w_rs1_val),
    .o_rs2_dat (w_rs2_val),
    .i_we      (w_rf_we),
    .i_rd_addr (w_rd),
    .i_rd_dat  (w_wb)
  );

  rv_dmem #(.DMEM_WORDS(DMEM_WORDS), .AW(AW)) memory (
    .i_clock  (clock),
    .i_reset_n(reset),
    .i_we     (w_st_we),
    .i_be     (w_st_be),
    .i_idx    (w_didx),
    .i_wdata  (w_st_data),
    .o_rdata  (w_ld_word)
  );

  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_f3     = w_instr[14:12];
  assign w_f7     = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign w_mem_addr = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_didx     = AW'(w_mem_addr[31:2] % 30'(DMEM_WORDS));
  assign w_ld_byte  = 8'(w_ld_word >> {w_mem_addr[1:0], 3'b000});
  assign w_ld_half  = w_mem_addr[1] ? w_ld_word[31:16] : w_ld_word[15:0];

  always_comb begin
    w_rd_we   = 1'b0;
    w_wb      = '0;
    w_next_pc = w_pc + 32'd4;
    w_st_we   = 1'b0;
    w_st_be   = '0;
    w_st_data = '0;
    case (w_opcode)
      OP_LUI:   begin w_rd_we = 1'b1; w_wb = w_imm_u;        end
      OP_AUIPC: begin w_rd_we = 1'b1; w_wb = w_pc + w_imm_u; end
      OP_JAL: begin
        w_rd_we   = 1'b1;
        w_wb      = w_pc + 32'd4;
        w_next_pc = w_pc + w_imm_j;
      end
      OP_JALR: if (w_f3 == 3'b000) begin
        w_rd_we   = 1'b1;
        w_wb      = w_pc + 32'd4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
      end
      OP_BRANCH: if (f_taken(w_f3, w_rs1_val, w_rs2_val)) w_next_pc = w_pc + w_imm_b;
      OP_LOAD: begin
        w_rd_we = 1'b1;
        case (w_f3)
          3'b000:  w_wb = {{24{w_ld_byte[7]}}, w_ld_byte};
          3'b001:  w_wb = {{16{w_ld_half[15]}}, w_ld_half};
          3'b010:  w_wb = w_ld_word;
          3'b100:  w_wb = {24'b0, w_ld_byte};
          3'b101:  w_wb = {16'b0, w_ld_half};
          default: w_rd_we = 1'b0;
        endcase
      end
      OP_STORE: begin
        w_st_we = 1'b1;
        case (w_f3)
          3'b000: begin w_st_be = 4'b0001 << w_mem_addr[1:0]; w_st_data = {4{w_rs2_val[7:0]}}; end
          3'b001: begin w_st_be = w_mem_addr[1] ? 4'b1100 : 4'b0011; w_st_data = {2{w_rs2_val[15:0]}}; end
          3'b010: begin w_st_be = 4'b1111; w_st_data = w_rs2_val; end
          default: w_st_we = 1'b0;
        endcase
      end
      // Shift-immediates carry funct7 in the immediate; only the canonical encodings are legal.
      OP_IMM: if ((w_f3 == 3'b001) ? (w_f7 == 7'h00)
                                   : ((w_f3 != 3'b101) || (w_f7 == 7'h00) || (w_f7 == 7'h20))) begin
        w_rd_we = 1'b1;
        w_wb    = f_alu(w_f3, (w_f3 == 3'b101) && w_instr[30], w_rs1_val, w_imm_i);
      end
      OP_REG: if ((w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))) begin
        w_rd_we = 1'b1;
        w_wb    = f_alu(w_f3, w_instr[30], w_rs1_val, w_rs2_val);
      end
      default: ;
    endcase
  end

  assign w_rf_we = w_rd_we && (w_rd != 5'd0);
  assign out     = (reset && w_rf_we) ? w_wb : '0;
endmodule

// File: tb/tb_risc_v_cpu_core.sv
// Bench for risc_v_cpu_core: directed programs plus a random program against an instruction-level model.
module tb_risc_v_cpu_core;
  localparam int IMEM_BYTES = 1024;
  localparam int DMEM_WORDS = 64;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] out;
    int          rd;
    logic [31:0] rd_val;
    bit          st;
    int          st_idx;
    logic [31:0] st_word;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_imem [IMEM_BYTES];
  logic [31:0] m_dmem [DMEM_WORDS];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] prog [$];
  exp_t        exp_q [$];
  exp_t        mon_e, pend;
  bit          pend_v = 0;

  risc_v_cpu_core #(.IMEM_BYTES(IMEM_BYTES), .DMEM_WORDS(DMEM_WORDS), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .out  (out)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [6:0]  f7;
    int          k;
    rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3  = 3'($urandom); i12 = 12'($urandom);
    k   = $urandom_range(0, 19);
    case (k)
      0, 1: return enc_u(20'($urandom), rd, 7'h37);
      2:    return enc_u(20'($urandom), rd, 7'h17);
      3, 4, 5, 6: begin
        if (f3 == 3'd1) i12 = {7'h00, i12[4:0]};
        else if (f3 == 3'd5) i12 = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, i12[4:0]};
        return enc_i(i12, rs1, f3, rd, 7'h13);
      end
      7, 8, 9: begin
        f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd);
      end
      10, 11: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        return enc_i(i12, rs1, f3, rd, 7'h03);
      end
      12, 13: return enc_s(i12, rs2, rs1, 3'($urandom_range(0, 2)));
      14, 15: begin
        while ((f3 == 3'd2) || (f3 == 3'd3)) f3 = 3'($urandom);
        return enc_b(13'(($urandom_range(0, 31) - 16) * 4), rs2, rs1, f3);
      end
      16:     return enc_j(21'(($urandom_range(0, 31) - 16) * 4), rd);
      17:     return enc_i(12'($urandom_range(0, 255)), 5'd0, 3'd0, rd, 7'h67);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] ifetch(input logic [31:0] a);
    return (a < IMEM_BYTES) ? m_imem[int'(a)] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step(output exp_t e);
    logic [31:0] ins, a, b, ii, si, bi, ji, res, nxt, ad, w;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    int          rd, lane, idx;
    bit          wr, take;
    ins = {ifetch(m_pc + 3), ifetch(m_pc + 2), ifetch(m_pc + 1), ifetch(m_pc)};
    opc = ins[6:0]; rd = int'(ins[11:7]); f3 = ins[14:12]; f7 = ins[31:25];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    ii  = 32'($signed(ins) >>> 20);
    si  = {ii[31:5], ins[11:7]};
    bi  = {ii[31:12], ins[7], ins[30:25], ins[11:8], 1'b0};
    ji  = {ii[31:20], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 4; wr = 0; res = 0; take = 0;
    e.pc = m_pc; e.out = 0; e.rd = 0; e.rd_val = 0; e.st = 0; e.st_idx = 0; e.st_word = 0;
    case (opc)
      7'h37: begin wr = 1; res = {ins[31:12], 12'h000}; end
      7'h17: begin wr = 1; res = m_pc + {ins[31:12], 12'h000}; end
      7'h6F: begin wr = 1; res = m_pc + 4; nxt = m_pc + ji; end
      7'h67: if (f3 == 0) begin wr = 1; res = m_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 0;
        endcase
        if (take) nxt = m_pc + bi;
      end
      7'h03: begin
        ad = a + ii; idx = int'((ad >> 2) % DMEM_WORDS); w = m_dmem[idx]; lane = int'(ad[1:0]);
        wr = 1;
        case (f3)
          3'd0: res = 32'($signed(w[8*lane +: 8]));
          3'd1: res = 32'($signed(w[16*int'(ad[1]) +: 16]));
          3'd2: res = w;
          3'd4: res = {24'h0, w[8*lane +: 8]};
          3'd5: res = {16'h0, w[16*int'(ad[1]) +: 16]};
          default: wr = 0;
        endcase
      end
      7'h23: if (f3 < 3) begin
        ad = a + si; idx = int'((ad >> 2) % DMEM_WORDS); w = m_dmem[idx]; lane = int'(ad[1:0]);
        if (f3 == 0) w[8*lane +: 8] = b[7:0];
        else if (f3 == 1) w[16*int'(ad[1]) +: 16] = b[15:0];
        else w = b;
        m_dmem[idx] = w;
        e.st = 1; e.st_idx = idx; e.st_word = w;
      end
      7'h13: if ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20)) || (f3 != 1 && f3 != 5)) begin
        wr = 1; res = ref_alu(f3, (f3 == 5) && (f7 == 7'h20), a, ii);
      end
      7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
        wr = 1; res = ref_alu(f3, f7 == 7'h20, a, b);
      end
      default: ;
    endcase
    if (wr && rd != 0) begin
      m_regs[rd] = res; e.out = res; e.rd = rd; e.rd_val = res;
    end
    m_pc = nxt;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    #1;
    if (pend_v) begin
      pend_v = 0;
      if (pend.rd != 0) check("wb_reg", dut.registers_bank.registers[pend.rd], pend.rd_val);
      if (pend.st) check("st_mem", dut.memory.memory[pend.st_idx], pend.st_word);
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pc", dut.program_counter.pc_addr, mon_e.pc);
      check("out", out, mon_e.out);
      pend = mon_e; pend_v = 1;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clock);
      model_step(e);
      exp_q.push_back(e);
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_prog();
    logic [31:0] w;
    for (int i = 0; i < IMEM_BYTES; i++) begin
      w = (i / 4 < prog.size()) ? prog[i / 4] : 32'h0;
      dut.uut_instruction.memory[i] = w[8*(i % 4) +: 8];
      m_imem[i] = w[8*(i % 4) +: 8];
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 0;
    #1;
    check("rst_pc", dut.program_counter.pc_addr, 32'h0);
    check("rst_out", out, 32'h0);
    for (int i = 0; i < 32; i++) check("rst_reg", dut.registers_bank.registers[i], 32'h0);
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1;
  endtask

  task automatic chk_reg(input string nm, input int idx, input logic [31:0] exp);
    check(nm, dut.registers_bank.registers[idx], exp);
  endtask

  task automatic set_dmem(input int idx, input logic [31:0] v);
    dut.memory.memory[idx] = v;
    m_dmem[idx] = v;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 0;
    m_pc  = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int i = 0; i < DMEM_WORDS; i++) set_dmem(i, $urandom);
    #1;
    check("init_pc", dut.program_counter.pc_addr, 32'h0);
    check("init_out", out, 32'h0);

    // Arithmetic, LUI, store and byte loads, writes to x0, all-zero word
    prog = '{enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13),
             enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13),
             enc_u(20'h12345, 5'd3, 7'h37),
             enc_i(12'h678, 5'd3, 3'd0, 5'd3, 7'h13),
             enc_s(12'd8, 5'd3, 5'd0, 3'd2),
             enc_i(12'd9, 5'd0, 3'd0, 5'd4, 7'h03),
             enc_i(12'd11, 5'd0, 3'd4, 5'd5, 7'h03),
             enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13),
             32'h0};
    load_prog();
    release_reset();
    run(1); settle();
    chk_reg("a_x1", 1, 32'd5);
    check("a_pc1", dut.program_counter.pc_addr, 32'h4);
    run(1); settle();
    chk_reg("a_x2", 2, 32'hFFFF_FFFE);
    check("a_pc2", dut.program_counter.pc_addr, 32'h8);
    run(3); settle();
    chk_reg("a_x3", 3, 32'h1234_5678);
    check("a_mem2", dut.memory.memory[2], 32'h1234_5678);
    run(2); settle();
    chk_reg("a_x4", 4, 32'h0000_0056);
    chk_reg("a_x5", 5, 32'h0000_0012);
    run(2); settle();
    chk_reg("a_x0", 0, 32'h0);
    check("a_pc_end", dut.program_counter.pc_addr, 32'h24);

    // Reset while the store is the current instruction: it must not land
    do_reset();
    set_dmem(2, 32'hDEAD_BEEF);
    release_reset();
    run(4);
    do_reset();
    repeat (2) @(posedge clock);
    #1;
    check("abort_mem2", dut.memory.memory[2], 32'hDEAD_BEEF);

    // Branches signed vs unsigned, JAL, JALR with odd target
    prog = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13),
             enc_b(13'd8, 5'd0, 5'd1, 3'd4),
             enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13),
             enc_b(13'd8, 5'd0, 5'd1, 3'd6),
             enc_j(21'd16, 5'd0),
             enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13),
             enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13),
             enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13),
             enc_j(21'd16, 5'd1),
             enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13),
             32'h0,
             enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13),
             enc_i(12'd1, 5'd1, 3'd0, 5'd2, 7'h67)};
    load_prog();
    release_reset();
    run(2); settle();
    check("b_blt_taken", dut.program_counter.pc_addr, 32'hC);
    run(1); settle();
    check("b_bltu_not", dut.program_counter.pc_addr, 32'h10);
    run(2); settle();
    chk_reg("b_jal_x1", 1, 32'h24);
    check("b_jal_pc", dut.program_counter.pc_addr, 32'h30);
    run(1); settle();
    check("b_jalr_pc", dut.program_counter.pc_addr, 32'h24);
    chk_reg("b_jalr_x2", 2, 32'h34);
    run(2); settle();
    check("b_nop_pc", dut.program_counter.pc_addr, 32'h2C);
    chk_reg("b_x0", 0, 32'h0);
    chk_reg("b_skipped_x7", 7, 32'h0);

    // Random program, mid-run reset, restart from address 0
    do_reset();
    prog.delete();
    for (int i = 0; i < IMEM_BYTES / 4; i++) prog.push_back(gen_instr());
    load_prog();
    release_reset();
    run(600); settle();
    for (int i = 0; i < 32; i++) chk_reg("rnd_reg", i, m_regs[i]);
    for (int i = 0; i < DMEM_WORDS; i++) check("rnd_mem", dut.memory.memory[i], m_dmem[i]);
    do_reset();
    release_reset();
    run(40); settle();
    @(negedge clock);
    #3;
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/risc_v_cpu_core.md
Name: risc_v_cpu_core

Overview:
- Single-cycle RV32I processor: fetch, decode, execute, memory access and write-back all complete in one clock.
- Contains four named sub-blocks whose state the verification bench reads hierarchically:
  - instruction memory `uut_instruction.memory`: byte array;
  - program counter `program_counter.pc_addr`;
  - register file `registers_bank.registers`: 32 x 32-bit;
  - data memory `memory.memory`: word array.
- Top of the CPU hierarchy; there is no external bus.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes (byte-addressed, little-endian).
- DMEM_WORDS, 64, data memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value applied during reset.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- out    output 32  write-back data of the instruction executing this cycle; 0 when no register is written.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_addr = RESET_PC.
  - All 32 registers = 0.
  - Instruction memory and data memory are not cleared; the bench preloads instruction memory.
  - out = 0 while reset is asserted.
  - Reset asserted mid-program aborts the current instruction with no register or memory write.
- Fetch:
  - instr = {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}.
  - Byte addresses at or above IMEM_BYTES read 0.
- Latency: exactly one instruction retires per rising clock edge. After edge N, the register, PC and memory effects of the instruction at the pre-edge PC are all visible.
- Next PC:
  - Default: pc+4.
  - Taken branch / JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - PC wraps modulo 2^32.
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Unsupported or illegal encodings (including all-zero words, FENCE, ECALL, EBREAK, CSR*) behave as NOP: pc+4, no writes.
- Immediates: I/S/B/U/J formats, sign-extended from instr[31].
- Arithmetic:
  - 32-bit two's-complement, overflow ignored.
  - Shift amount is the low 5 bits.
  - SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
- Register file:
  - Two combinational read ports, one write port on the clock edge.
  - Writes to x0 are discarded; x0 always reads 0.
  - Reading a register written in the same instruction returns the old value.
- Data memory:
  - Effective address = rs1 + imm; word index = addr[31:2] modulo DMEM_WORDS.
  - Stores write on the rising edge. SB/SH use byte enables selected by addr[1:0] and addr[1]; other bytes are unchanged.
  - Loads are combinational and byte/half-selected by the low address bits. LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned LW/SW ignore addr[1:0]. Misaligned LH/SH ignore addr[0].
- JAL/JALR write pc+4 to rd.
- out equals the rd write value:
  - ALU result, load data, pc+4 or U-immediate;
  - 0 for stores, branches and NOPs;
  - 0 when rd is x0.

Test Plan:
- Reset then ADDI x1,x0,5; ADDI x2,x1,-7 -> after edge 1 x1=5, pc=4; after edge 2 x2=0xFFFFFFFE, pc=8.
- LUI x3,0x12345; ADDI x3,x3,0x678; SW x3,8(x0); LB x4,9(x0); LBU x5,11(x0) -> x3=0x12345678, memory[2]=0x12345678, x4=0x00000056, x5=0x00000012.
- ADDI x1,x0,-1; BLT x1,x0,+8 (taken) vs BLTU x1,x0,+8 (not taken) -> pc advances by 8 vs 4.
- JAL x1,+16 at pc=0x20 -> x1=0x24, pc=0x30; JALR x2,x1,1 -> pc=0x24, x2=0x34.
- ADDI x0,x0,9; all-zero instruction word -> x0 stays 0, pc+4 each, out=0.
- Assert reset low mid-run after several instructions -> pc=0 and all registers 0 immediately, without waiting for a clock edge; execution restarts from address 0 after release.
